accel_seq_ctrl: RTL and testbench
=================================

// Module: accel_seq_ctrl
// PURPOSE
// - Upstream sequencer for the accelerator top level. Drives every enable/clear input of the
//   accelerator and handshakes weight, activation and result rows with the host.
// - Runs one GEMM tile per start: load weights, pre-store them, stream activations, drain,
//   accumulate over K tiles, then unload results.
// PARAMETERS
// - ARRAY_W    8   systolic array width (rows per weight tile)
// - ROWS_W     8   width of the activation-row count
// - KT_W       4   width of the K-tile count
// - DRAIN_LAT  15  cycles from last activation out to last valid sum (2*ARRAY_W-1)
// PORTS
// - clk          in   1       clock, rising edge
// - rst          in   1       asynchronous reset, active-high
// - start        in   1       launch job; sampled only in IDLE
// - num_rows     in   ROWS_W  activation rows M per tile (0 is treated as 1)
// - num_ktiles   in   KT_W    K tiles to accumulate (0 is treated as 1)
// - relu_cfg     in   1       assert relu_en during OUT
// - wgt_valid/wgt_ready  in/out 1  host weight-row handshake
// - act_valid/act_ready  in/out 1  host activation-row handshake
// - out_valid/out_ready  out/in 1  result-row handshake
// - busy         out  1       high from accepted start until done
// - done         out  1       one-cycle pulse at job end
// - ib_load_en, ib_out_en, ib_delay_clear       out 1  input buffer controls
// - wb_load_en, wb_out_en, write_weight_en      out 1  weight buffer and array controls
// - ob_load_en, ob_out_en, ob_load_clear, ob_acc_enable, ob_acc_clear, relu_en  out 1
// BEHAVIOUR
// - Reset: state=IDLE, all counters 0, every output 0. Reset mid-job aborts with no done pulse.
// - States: IDLE -> W_LOAD -> W_SHIFT -> A_LOAD -> A_STREAM -> DRAIN -> (ACC | OUT) -> FIN -> IDLE.
// - IDLE: start=1 latches num_rows/num_ktiles, sets busy, pulses ib_delay_clear, ob_load_clear
//   and ob_acc_clear for one cycle, then enters W_LOAD.
// - W_LOAD: wgt_ready=1, wb_load_en=wgt_valid&wgt_ready. After ARRAY_W beats -> W_SHIFT.
// - W_SHIFT: wb_out_en=write_weight_en=1 for exactly ARRAY_W cycles -> A_LOAD.
// - A_LOAD: act_ready=1, ib_load_en per beat. After M beats -> A_STREAM.
// - A_STREAM: ib_out_en=1 for M cycles. ob_load_en rises DRAIN_LAT-ARRAY_W+1 cycles after
//   A_STREAM entry and stays high for M cycles, which may extend into DRAIN.
// - DRAIN: counts out the remainder of the DRAIN_LAT window. Next state is ACC if tiles remain,
//   else OUT.
// - ACC: one-cycle ob_acc_enable, ib_delay_clear pulse, ob_load_clear pulse, tile count +1,
//   -> W_LOAD.
// - OUT: out_valid=1, ob_out_en=out_valid&out_ready, relu_en=relu_cfg. After M beats -> FIN.
// - FIN: done=1 for one cycle, busy drops in the same cycle -> IDLE.
// - Handshake rules:
//   - A beat transfers on valid&ready. Ready never depends combinationally on valid.
//   - out_valid holds until accepted.
// - Boundaries:
//   - start while busy is ignored.
//   - Host stalls in W_LOAD/A_LOAD/OUT freeze the counters.
//   - M=1 and K=1 are legal.
//   - All counters compare against the latched count minus 1, with no wrap.
// CONFIGURATION
// - ACCEL_SEQ_PERF_CNT_EN defined: adds output perf_cycles [31:0].
//   - Cleared on accepted start, counts every busy cycle, holds after done.
//   - Saturates at 32'hFFFF_FFFF.
// - Undefined: no port and no counter logic.
// STRUCTURE
// - accel_seq_pkg.vh: state encoding localparams, ROWS_W/KT_W defaults, DRAIN_LAT derivation.
// - One sub-module, accel_beat_cnt: a loadable down-counter with a last flag. It is reused for
//   the weight, activation, stream, drain and output beats.
// TESTING
// - Reset asserted mid-A_STREAM -> all outputs 0 next cycle, no done, IDLE after release.
// - M=4, K=1, host always valid/ready:
//   - exactly 8 wb_load_en, 8 write_weight_en, 4 ib_load_en, 4 ib_out_en, 4 ob_load_en and
//     4 ob_out_en cycles, then one done.
// - M=3, K=3 -> ob_acc_enable pulses twice, W_LOAD entered 3 times, 3 result beats at the end.
// - out_ready toggled 1,0,0,1 in OUT -> out_valid held, ob_out_en high only when out_ready=1.
// - start pulsed while busy plus num_rows=0 -> second start ignored, job runs as M=1.
// - ACCEL_SEQ_PERF_CNT_EN, M=4, K=1, no stalls -> perf_cycles equals the computed busy-cycle count.

Source files
------------

// File: rtl/accel_seq_pkg.sv
// Shared constants for the GEMM tile sequencer: state encoding,
// default widths and the drain-latency / counter-width derivation.
`timescale 1ns/1ps
package accel_seq_pkg;

   localparam int ARRAY_W_D   = 8;
   localparam int ROWS_W_D    = 8;
   localparam int KT_W_D      = 4;
   localparam int DRAIN_LAT_D = 2*ARRAY_W_D-1;

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_W_LOAD   = 4'd1;
   localparam logic [3:0] S_W_SHIFT  = 4'd2;
   localparam logic [3:0] S_A_LOAD   = 4'd3;
   localparam logic [3:0] S_A_STREAM = 4'd4;
   localparam logic [3:0] S_DRAIN    = 4'd5;
   localparam logic [3:0] S_ACC      = 4'd6;
   localparam logic [3:0] S_OUT      = 4'd7;
   localparam logic [3:0] S_FIN      = 4'd8;

   typedef enum logic [1:0] {
      OBP_IDLE,
      OBP_WAIT,
      OBP_LOAD
   } ob_phase_e;

   // wide enough for both a row count minus one and the drain window
   function automatic int cnt_w(input int rows_w, input int lat);
      int l;
      l = $clog2(lat);
      return (rows_w > l) ? rows_w : l;
   endfunction

endpackage

// File: rtl/accel_beat_cnt.sv
// Loadable down-counter with a last flag; holds at zero
// rather than wrapping.
`timescale 1ns/1ps
module accel_beat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   input  logic         i_dec,
   output logic         o_last
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_val;
      else if (i_dec && r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_last = (r_cnt == '0);

endmodule

// File: rtl/accel_seq_ctrl.sv
// GEMM tile sequencer: weight load/shift, activation stream, drain,
// K-tile accumulate, result unload. ACCEL_SEQ_PERF_CNT_EN adds perf_cycles.
`timescale 1ns/1ps
module accel_seq_ctrl
   import accel_seq_pkg::*;
#(
   parameter int ARRAY_W   = ARRAY_W_D,
   parameter int ROWS_W    = ROWS_W_D,
   parameter int KT_W      = KT_W_D,
   parameter int DRAIN_LAT = 2*ARRAY_W-1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ROWS_W-1:0] num_rows,
   input  logic [KT_W-1:0]   num_ktiles,
   input  logic              relu_cfg,
   input  logic              wgt_valid,
   output logic              wgt_ready,
   input  logic              act_valid,
   output logic              act_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              ib_load_en,
   output logic              ib_out_en,
   output logic              ib_delay_clear,
   output logic              wb_load_en,
   output logic              wb_out_en,
   output logic              write_weight_en,
   output logic              ob_load_en,
   output logic              ob_out_en,
   output logic              ob_load_clear,
   output logic              ob_acc_enable,
   output logic              ob_acc_clear,
   output logic              relu_en
`ifdef ACCEL_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   localparam int CNT_W = cnt_w(ROWS_W, DRAIN_LAT);
   localparam logic [CNT_W-1:0] ARR_M1 = CNT_W'(ARRAY_W-1);
   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(DRAIN_LAT-1);
   localparam logic [CNT_W-1:0] OBW_M1 = CNT_W'(DRAIN_LAT-ARRAY_W);

   logic [3:0]        r_state;
   logic [3:0]        w_nxt;
   logic [ROWS_W-1:0] r_m_m1;
   logic [KT_W-1:0]   r_kt_m1;
   logic [KT_W-1:0]   r_kt;
   logic              w_accept;
   logic              w_beat;
   logic              w_ld;
   logic [CNT_W-1:0]  w_ld_val;
   logic [CNT_W-1:0]  w_m_val;
   logic              w_last;
   ob_phase_e         r_obp;
   ob_phase_e         w_obp_nxt;
   logic              w_ob_ld;
   logic              w_ob_dec;
   logic [CNT_W-1:0]  w_ob_val;
   logic              w_ob_last;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_m_val  = CNT_W'(r_m_m1);

   always_comb begin
      w_nxt    = r_state;
      w_beat   = 1'b0;
      w_ld     = 1'b0;
      w_ld_val = '0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nxt    = S_W_LOAD;
               w_ld     = 1'b1;
               w_ld_val = ARR_M1;
            end
         end
         S_W_LOAD: begin
            w_beat = wgt_valid;
            if (w_beat && w_last) begin
               w_nxt    = S_W_SHIFT;
               w_ld     = 1'b1;
               w_ld_val = ARR_M1;
            end
         end
         S_W_SHIFT: begin
            w_beat = 1'b1;
            if (w_last) begin
               w_nxt    = S_A_LOAD;
               w_ld     = 1'b1;
               w_ld_val = w_m_val;
            end
         end
         S_A_LOAD: begin
            w_beat = act_valid;
            if (w_beat && w_last) begin
               w_nxt    = S_A_STREAM;
               w_ld     = 1'b1;
               w_ld_val = w_m_val;
            end
         end
         S_A_STREAM: begin
            w_beat = 1'b1;
            if (w_last) begin
               w_nxt    = S_DRAIN;
               w_ld     = 1'b1;
               w_ld_val = LAT_M1;
            end
         end
         S_DRAIN: begin
            w_beat = 1'b1;
            if (w_last) begin
               if (r_kt != r_kt_m1) begin
                  w_nxt = S_ACC;
               end else begin
                  w_nxt    = S_OUT;
                  w_ld     = 1'b1;
                  w_ld_val = w_m_val;
               end
            end
         end
         S_ACC: begin
            w_nxt    = S_W_LOAD;
            w_ld     = 1'b1;
            w_ld_val = ARR_M1;
         end
         S_OUT: begin
            w_beat = out_ready;
            if (w_beat && w_last)
               w_nxt = S_FIN;
         end
         S_FIN:   w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   accel_beat_cnt #(.W(CNT_W)) u_beat (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_ld),
      .i_val  (w_ld_val),
      .i_dec  (w_beat),
      .o_last (w_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_m_m1  <= '0;
         r_kt_m1 <= '0;
         r_kt    <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_accept) begin
            r_m_m1  <= (num_rows == '0) ? '0 : num_rows - 1'b1;
            r_kt_m1 <= (num_ktiles == '0) ? '0 : num_ktiles - 1'b1;
            r_kt    <= '0;
         end else if (r_state == S_ACC) begin
            r_kt <= r_kt + 1'b1;
         end
      end
   end

   // ob_load_en trails stream entry by the array pipeline depth
   always_comb begin
      w_obp_nxt = r_obp;
      w_ob_ld   = 1'b0;
      w_ob_dec  = 1'b0;
      w_ob_val  = '0;
      if (r_state == S_A_LOAD && w_beat && w_last) begin
         w_obp_nxt = OBP_WAIT;
         w_ob_ld   = 1'b1;
         w_ob_val  = OBW_M1;
      end else if (r_obp == OBP_WAIT) begin
         w_ob_dec = 1'b1;
         if (w_ob_last) begin
            w_obp_nxt = OBP_LOAD;
            w_ob_ld   = 1'b1;
            w_ob_val  = w_m_val;
         end
      end else if (r_obp == OBP_LOAD) begin
         w_ob_dec = 1'b1;
         if (w_ob_last)
            w_obp_nxt = OBP_IDLE;
      end
   end

   accel_beat_cnt #(.W(CNT_W)) u_ob (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_ob_ld),
      .i_val  (w_ob_val),
      .i_dec  (w_ob_dec),
      .o_last (w_ob_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_obp <= OBP_IDLE;
      else
         r_obp <= w_obp_nxt;
   end

   assign wgt_ready       = (r_state == S_W_LOAD);
   assign act_ready       = (r_state == S_A_LOAD);
   assign out_valid       = (r_state == S_OUT);
   assign busy            = (r_state != S_IDLE) && (r_state != S_FIN);
   assign done            = (r_state == S_FIN);
   assign wb_load_en      = wgt_ready && wgt_valid;
   assign wb_out_en       = (r_state == S_W_SHIFT);
   assign write_weight_en = (r_state == S_W_SHIFT);
   assign ib_load_en      = act_ready && act_valid;
   assign ib_out_en       = (r_state == S_A_STREAM);
   assign ib_delay_clear  = w_accept || (r_state == S_ACC);
   assign ob_load_clear   = w_accept || (r_state == S_ACC);
   assign ob_acc_clear    = w_accept;
   assign ob_acc_enable   = (r_state == S_ACC);
   assign ob_load_en      = (r_obp == OBP_LOAD);
   assign ob_out_en       = out_valid && out_ready;
   assign relu_en         = out_valid && relu_cfg;

`ifdef ACCEL_SEQ_PERF_CNT_EN
   logic [31:0] r_perf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_perf <= '0;
      else if (w_accept)
         r_perf <= '0;
      else if (busy && r_perf != 32'hFFFF_FFFF)
         r_perf <= r_perf + 32'd1;
   end

   assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Directed bench for accel_seq_ctrl: table of whole jobs with
// hand-computed event counts plus reset and out_ready corner sequences.
`timescale 1ns/1ps
module tb_accel_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] num_rows;
   logic [3:0] num_ktiles;
   logic       relu_cfg;
   logic       wgt_valid, wgt_ready;
   logic       act_valid, act_ready;
   logic       out_valid, out_ready;
   logic       busy, done;
   logic       ib_load_en, ib_out_en, ib_delay_clear;
   logic       wb_load_en, wb_out_en, write_weight_en;
   logic       ob_load_en, ob_out_en, ob_load_clear;
   logic       ob_acc_enable, ob_acc_clear, relu_en;
`ifdef ACCEL_SEQ_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif

   accel_seq_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .num_rows        (num_rows),
      .num_ktiles      (num_ktiles),
      .relu_cfg        (relu_cfg),
      .wgt_valid       (wgt_valid),
      .wgt_ready       (wgt_ready),
      .act_valid       (act_valid),
      .act_ready       (act_ready),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .busy            (busy),
      .done            (done),
      .ib_load_en      (ib_load_en),
      .ib_out_en       (ib_out_en),
      .ib_delay_clear  (ib_delay_clear),
      .wb_load_en      (wb_load_en),
      .wb_out_en       (wb_out_en),
      .write_weight_en (write_weight_en),
      .ob_load_en      (ob_load_en),
      .ob_out_en       (ob_out_en),
      .ob_load_clear   (ob_load_clear),
      .ob_acc_enable   (ob_acc_enable),
      .ob_acc_clear    (ob_acc_clear),
      .relu_en         (relu_en)
`ifdef ACCEL_SEQ_PERF_CNT_EN
      ,
      .perf_cycles     (perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] m;
      logic [3:0] k;
      logic       relu;
      bit         restart;
      int         busy;
      int         wb;
      int         ww;
      int         ibl;
      int         ibo;
      int         obl;
      int         obo;
      int         acc;
      int         wl;
      int         clr;
      int         rl;
   } vec_t;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input longint act,
                        input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [16:0] outs();
      return {wgt_ready, act_ready, out_valid, busy, done,
              ib_load_en, ib_out_en, ib_delay_clear,
              wb_load_en, wb_out_en, write_weight_en,
              ob_load_en, ob_out_en, ob_load_clear,
              ob_acc_enable, ob_acc_clear, relu_en};
   endfunction

   task automatic run_job(input int idx, input vec_t v);
      int   c_busy, c_wb, c_ww, c_ibl, c_ibo, c_obl, c_obo;
      int   c_acc, c_wl, c_clr, c_rl, c_done, c_aclr;
      logic prev_wr;
      bit   got_done;
      c_busy = 0; c_wb = 0; c_ww = 0; c_ibl = 0; c_ibo = 0;
      c_obl = 0; c_obo = 0; c_acc = 0; c_wl = 0; c_clr = 0;
      c_rl = 0; c_done = 0; c_aclr = 0;
      prev_wr = 1'b0;
      got_done = 1'b0;
      @(posedge clk); #1;
      num_rows   = v.m;
      num_ktiles = v.k;
      relu_cfg   = v.relu;
      wgt_valid  = 1'b1;
      act_valid  = 1'b1;
      out_ready  = 1'b1;
      start      = 1'b1;
      for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
         @(negedge clk);
         c_busy += int'(busy);
         c_wb   += int'(wb_load_en);
         c_ww   += int'(write_weight_en);
         c_ibl  += int'(ib_load_en);
         c_ibo  += int'(ib_out_en);
         c_obl  += int'(ob_load_en);
         c_obo  += int'(ob_out_en);
         c_acc  += int'(ob_acc_enable);
         c_clr  += int'(ib_delay_clear);
         c_aclr += int'(ob_acc_clear);
         c_rl   += int'(relu_en);
         c_done += int'(done);
         if (wgt_ready && !prev_wr) c_wl++;
         prev_wr = wgt_ready;
         if (done) begin
            got_done = 1'b1;
            check($sformatf("v%0d_busy_at_done", idx), busy, 0);
`ifdef ACCEL_SEQ_PERF_CNT_EN
            check($sformatf("v%0d_perf", idx), perf_cycles, v.busy);
`endif
         end
         @(posedge clk); #1;
         start = v.restart && cyc == 5;
         if (v.restart && cyc == 5) num_rows = 8'd5;
      end
      start = 1'b0;
      check($sformatf("v%0d_done_seen", idx), got_done, 1);
      check($sformatf("v%0d_busy", idx), c_busy, v.busy);
      check($sformatf("v%0d_wb_load", idx), c_wb, v.wb);
      check($sformatf("v%0d_wr_weight", idx), c_ww, v.ww);
      check($sformatf("v%0d_ib_load", idx), c_ibl, v.ibl);
      check($sformatf("v%0d_ib_out", idx), c_ibo, v.ibo);
      check($sformatf("v%0d_ob_load", idx), c_obl, v.obl);
      check($sformatf("v%0d_ob_out", idx), c_obo, v.obo);
      check($sformatf("v%0d_acc_en", idx), c_acc, v.acc);
      check($sformatf("v%0d_wload_entry", idx), c_wl, v.wl);
      check($sformatf("v%0d_delay_clr", idx), c_clr, v.clr);
      check($sformatf("v%0d_acc_clr", idx), c_aclr, 1);
      check($sformatf("v%0d_relu", idx), c_rl, v.rl);
      check($sformatf("v%0d_done_cnt", idx), c_done, 1);
      @(negedge clk);
      check($sformatf("v%0d_idle_after", idx), outs(), 17'd0);
   endtask

   vec_t vt[5];

   initial begin
      logic pat[4];
      bit   seen;
      int   nz;

      vt[0] = '{8'd4, 4'd1, 1'b0, 1'b0, 43, 8, 8, 4, 4, 4, 4, 0, 1, 1, 0};
      vt[1] = '{8'd3, 4'd3, 1'b1, 1'b0, 116, 24, 24, 9, 9, 9, 3, 2, 3, 3, 3};
      vt[2] = '{8'd1, 4'd1, 1'b1, 1'b0, 34, 8, 8, 1, 1, 1, 1, 0, 1, 1, 1};
      vt[3] = '{8'd0, 4'd0, 1'b0, 1'b1, 34, 8, 8, 1, 1, 1, 1, 0, 1, 1, 0};
      vt[4] = '{8'd2, 4'd2, 1'b0, 1'b0, 73, 16, 16, 4, 4, 4, 2, 1, 2, 2, 0};
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

      rst = 1'b1; start = 1'b0; num_rows = '0; num_ktiles = '0;
      relu_cfg = 1'b0; wgt_valid = 1'b0; act_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("reset_outs", outs(), 17'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_outs", outs(), 17'd0);

      for (int i = 0; i < 5; i++) run_job(i, vt[i]);

      // out_ready pattern 1,0,0,1 while OUT holds three rows
      @(posedge clk); #1;
      num_rows = 8'd3; num_ktiles = 4'd1; relu_cfg = 1'b0;
      wgt_valid = 1'b1; act_valid = 1'b1; out_ready = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      check("outrdy_reach_out", seen, 1);
      check("outrdy_stall_en", ob_out_en, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         out_ready = pat[i];
         @(negedge clk);
         check($sformatf("outrdy_valid_%0d", i), out_valid, 1);
         check($sformatf("outrdy_en_%0d", i), ob_out_en, pat[i]);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("outrdy_last_en", ob_out_en, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("outrdy_done", done, 1);
      check("outrdy_busy", busy, 0);

      // reset in the middle of activation streaming
      @(posedge clk); #1;
      num_rows = 8'd4; num_ktiles = 4'd1; out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (ib_out_en) seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      check("rst_reach_stream", seen, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_outs", outs(), 17'd0);
`ifdef ACCEL_SEQ_PERF_CNT_EN
      check("rst_mid_perf", perf_cycles, 0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      nz = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (outs() != 17'd0) nz++;
      end
      check("rst_stays_idle", nz, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
